// File: rtl/pet_need_engine.sv
`default_nettype none
// ============================================================================
// Module      : pet_need_engine
// Description : N independent need levels with programmable per-channel
//               decay, care replenishment, health tracking and an
//               ALIVE/SICK/DEAD life-state machine.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pet_need_engine #(
  parameter int N_NEEDS       = 4,
  parameter int LVL_W         = 3,
  parameter int TICK_DIV      = 50000000,
  parameter int PERIOD_W      = 8,
  parameter int CARE_STEP     = 3,
  parameter int HIGH_THRESH   = 5,
  parameter int HEALTH_PERIOD = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  input  logic [N_NEEDS*PERIOD_W-1:0] decay_period,
  input  logic [N_NEEDS-1:0]          care,
  output logic [N_NEEDS*LVL_W-1:0]    level,
  output logic [N_NEEDS-1:0]          low_flag,
  output logic [LVL_W-1:0]            health,
  output logic                        sick,
  output logic                        dead,
  output logic                        tick
);

  localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_HT_W  = (HEALTH_PERIOD > 1) ? $clog2(HEALTH_PERIOD) : 1;

  localparam logic [LVL_W-1:0]   c_LVL_MAX   = {LVL_W{1'b1}};
  localparam logic [LVL_W:0]     c_CARE_STEP = (LVL_W+1)'(CARE_STEP);
  localparam logic [31:0]        c_HIGH      = 32'(HIGH_THRESH);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_HT_W-1:0]  c_HT_LAST   = c_HT_W'(HEALTH_PERIOD - 1);

  localparam logic [1:0] c_ST_ALIVE = 2'd0;
  localparam logic [1:0] c_ST_SICK  = 2'd1;
  localparam logic [1:0] c_ST_DEAD  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [c_PRE_W-1:0] r_pre;
  logic [c_HT_W-1:0]  r_htmr;
  logic [LVL_W-1:0]   r_health;
  logic [N_NEEDS-1:0] w_low;
  logic [N_NEEDS-1:0] w_zero;
  logic               w_anyZero;
  logic               w_allHigh;
  logic               w_tick;
  logic               w_isDead;
  logic               w_stateChange;
  logic               w_htmrRun;
  logic               w_htmrWrap;

  assign w_isDead = (r_state == c_ST_DEAD);

  // --------------------------------------------------------------------------
  // Tick prescaler: frozen while paused or dead so the residual count survives
  // --------------------------------------------------------------------------
  // Prescaler counter, wraps at TICK_DIV-1
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (!pause && !w_isDead) begin
      r_pre <= (r_pre == c_PRE_LAST) ? '0 : r_pre + c_PRE_W'(1);
    end
  end

  assign w_tick = (r_pre == c_PRE_LAST) && !pause && !w_isDead;
  assign tick   = w_tick;

  // --------------------------------------------------------------------------
  // Need channels
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_NEEDS; i++) begin : g_chan
    logic [PERIOD_W-1:0] w_period;
    logic [PERIOD_W-1:0] r_dcnt;
    logic [LVL_W-1:0]    r_lvl;
    logic [LVL_W:0]      w_careSum;

    assign w_period  = decay_period[i*PERIOD_W +: PERIOD_W];
    // One extra bit so a care near the top saturates instead of wrapping
    assign w_careSum = {1'b0, r_lvl} + c_CARE_STEP;

    // Level and decay counter: dead freezes, care beats a coincident decay
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_lvl  <= c_LVL_MAX;
        r_dcnt <= '0;
      end else if (w_isDead) begin
        r_lvl  <= r_lvl;
        r_dcnt <= r_dcnt;
      end else if (care[i]) begin
        r_lvl  <= (w_careSum > {1'b0, c_LVL_MAX}) ? c_LVL_MAX : w_careSum[LVL_W-1:0];
        r_dcnt <= '0;
      end else if (w_period == '0) begin
        r_dcnt <= '0;
      end else if (w_tick) begin
        // >= so that a period shortened mid-count fires on the next tick
        if (r_dcnt >= w_period - PERIOD_W'(1)) begin
          if (r_lvl != '0) begin
            r_lvl <= r_lvl - LVL_W'(1);
          end
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + PERIOD_W'(1);
        end
      end
    end

    assign level[i*LVL_W +: LVL_W] = r_lvl;
    assign w_low[i]  = (32'(r_lvl) < c_HIGH);
    assign w_zero[i] = (r_lvl == '0);
  end : g_chan

  assign low_flag  = w_low;
  assign w_anyZero = |w_zero;
  assign w_allHigh = ~|w_low;

  // --------------------------------------------------------------------------
  // Life-state machine
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_ST_ALIVE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: zero health wins over the sick/recover decision
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_ST_ALIVE: begin
        if (r_health == '0) begin
          w_nextState = c_ST_DEAD;
        end else if (w_anyZero) begin
          w_nextState = c_ST_SICK;
        end
      end
      c_ST_SICK: begin
        if (r_health == '0) begin
          w_nextState = c_ST_DEAD;
        end else if (!w_anyZero) begin
          w_nextState = c_ST_ALIVE;
        end
      end
      c_ST_DEAD: begin
        w_nextState = c_ST_DEAD;
      end
      default: begin
        w_nextState = c_ST_ALIVE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    sick = (r_state == c_ST_SICK);
    dead = (r_state == c_ST_DEAD);
  end

  // --------------------------------------------------------------------------
  // Health timer and health level
  // --------------------------------------------------------------------------
  assign w_stateChange = (w_nextState != r_state);
  assign w_htmrRun     = (r_state == c_ST_SICK) || ((r_state == c_ST_ALIVE) && w_allHigh);
  assign w_htmrWrap    = w_htmrRun && w_tick && (r_htmr == c_HT_LAST);

  // Health timer: counts ticks only while degrading or recovering
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_htmr <= '0;
    end else if (w_stateChange || !w_htmrRun) begin
      r_htmr <= '0;
    end else if (w_tick) begin
      r_htmr <= (r_htmr == c_HT_LAST) ? '0 : r_htmr + c_HT_W'(1);
    end
  end

  // Health level: sick loses one step per period, healthy alive gains one
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_health <= c_LVL_MAX;
    end else if (w_htmrWrap) begin
      if ((r_state == c_ST_SICK) && (r_health != '0)) begin
        r_health <= r_health - LVL_W'(1);
      end else if ((r_state == c_ST_ALIVE) && (r_health != c_LVL_MAX)) begin
        r_health <= r_health + LVL_W'(1);
      end
    end
  end

  assign health = r_health;

endmodule : pet_need_engine
`default_nettype wire

// File: tb/tb_pet_need_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pet_need_engine
// Description : Directed self-checking bench for pet_need_engine with a fast
//               prescaler (TICK_DIV=4) and short health period (2 ticks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pet_need_engine;

  localparam int N_NEEDS  = 4;
  localparam int LVL_W    = 3;
  localparam int PERIOD_W = 8;

  logic                        clk;
  logic                        rst;
  logic                        pause;
  logic [N_NEEDS*PERIOD_W-1:0] decayPeriod;
  logic [N_NEEDS-1:0]          care;
  logic [N_NEEDS*LVL_W-1:0]    level;
  logic [N_NEEDS-1:0]          lowFlag;
  logic [LVL_W-1:0]            health;
  logic                        sick;
  logic                        dead;
  logic                        tick;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int tc;

  pet_need_engine #(
    .N_NEEDS      (N_NEEDS),
    .LVL_W        (LVL_W),
    .TICK_DIV     (4),
    .PERIOD_W     (PERIOD_W),
    .CARE_STEP    (3),
    .HIGH_THRESH  (5),
    .HEALTH_PERIOD(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .decay_period(decayPeriod),
    .care        (care),
    .level       (level),
    .low_flag    (lowFlag),
    .health      (health),
    .sick        (sick),
    .dead        (dead),
    .tick        (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Advance to just after posedge number e (sampled at the following negedge)
  task automatic stepTo(input int e);
    while (ecnt < e) begin
      @(posedge clk);
      @(negedge clk);
      ecnt++;
    end
  endtask

  // Pack channel levels, channel 3 in the top field
  function automatic logic [31:0] pk(input int l3, input int l2, input int l1, input int l0);
    logic [11:0] v;
    v = {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
    return {20'd0, v};
  endfunction

  // Periods {ch3,ch2,ch1,ch0} = {1,0,3,2}
  localparam logic [31:0] c_PERIODS = {8'd1, 8'd0, 8'd3, 8'd2};

  initial begin
    rst = 1'b0; pause = 1'b0; care = '0; decayPeriod = c_PERIODS;
    stepTo(3);
    checkVal("rstLevel", 32'(level), pk(7, 7, 7, 7));
    checkVal("rstHealth", 32'(health), 32'd7);
    checkVal("rstSick", 32'(sick), 32'd0);
    checkVal("rstDead", 32'(dead), 32'd0);
    checkVal("rstTick", 32'(tick), 32'd0);
    checkVal("rstLow", 32'(lowFlag), 32'd0);
    rst = 1'b1; ecnt = 0;

    // Free-running decay
    stepTo(2);  checkVal("tickC3", 32'(tick), 32'd0);
    stepTo(3);  checkVal("tickC4", 32'(tick), 32'd1);
    stepTo(4);  checkVal("lvlE4", 32'(level), pk(6, 7, 7, 7));
    checkVal("tickC5", 32'(tick), 32'd0);
    stepTo(8);  checkVal("lvlE8", 32'(level), pk(5, 7, 7, 6));
    stepTo(12); checkVal("lvlE12", 32'(level), pk(4, 7, 6, 6));
    checkVal("lowE12", 32'(lowFlag), 32'b1000);
    checkVal("healthE12", 32'(health), 32'd7);

    // Care saturation and care winning over a decay tick
    care = 4'b0010; stepTo(13); care = '0;
    checkVal("careSat", 32'(level), pk(4, 7, 7, 6));
    stepTo(15); checkVal("tickC16", 32'(tick), 32'd1);
    care = 4'b0001; stepTo(16); care = '0;
    checkVal("careVsTick", 32'(level), pk(3, 7, 7, 7));
    stepTo(20); checkVal("dcntRestart", 32'(level), pk(2, 7, 7, 7));
    stepTo(24); checkVal("lvlE24", 32'(level), pk(1, 7, 6, 6));
    stepTo(28); checkVal("lvlE28", 32'(level), pk(0, 7, 6, 6));
    checkVal("sickLag", 32'(sick), 32'd0);
    stepTo(29); checkVal("sickE29", 32'(sick), 32'd1);

    // Sick health decay
    stepTo(35); checkVal("healthE35", 32'(health), 32'd7);
    stepTo(36); checkVal("healthE36", 32'(health), 32'd6);
    checkVal("lvlE36", 32'(level), pk(0, 7, 5, 5));
    stepTo(44); checkVal("healthE44", 32'(health), 32'd5);
    stepTo(52); checkVal("healthE52", 32'(health), 32'd4);
    checkVal("lvlE52", 32'(level), pk(0, 7, 4, 3));
    checkVal("lowE52", 32'(lowFlag), 32'b1011);

    // Simultaneous care, recovery to ALIVE, decay disabled
    care = 4'b1011; stepTo(53);
    checkVal("multiCare", 32'(level), pk(3, 7, 7, 6));
    checkVal("sickE53", 32'(sick), 32'd1);
    care = 4'b1000; decayPeriod = '0; stepTo(54); care = '0;
    checkVal("lvlE54", 32'(level), pk(6, 7, 7, 6));
    checkVal("sickE54", 32'(sick), 32'd0);
    checkVal("lowE54", 32'(lowFlag), 32'd0);

    // Health recovery while all levels are high
    stepTo(59); checkVal("healthE59", 32'(health), 32'd4);
    stepTo(60); checkVal("healthE60", 32'(health), 32'd5);
    stepTo(68); checkVal("healthE68", 32'(health), 32'd6);
    stepTo(76); checkVal("healthE76", 32'(health), 32'd7);
    stepTo(84); checkVal("healthSat", 32'(health), 32'd7);
    checkVal("frozenLvl", 32'(level), pk(6, 7, 7, 6));

    // Run health down to death via channel 3
    decayPeriod = {8'd1, 8'd0, 8'd0, 8'd0};
    stepTo(92);  checkVal("lvlE92", 32'(level), pk(4, 7, 7, 6));
    stepTo(108); checkVal("lvlE108", 32'(level), pk(0, 7, 7, 6));
    stepTo(109); checkVal("sickE109", 32'(sick), 32'd1);
    stepTo(116); checkVal("healthE116", 32'(health), 32'd6);
    stepTo(164); checkVal("healthE164", 32'(health), 32'd0);
    checkVal("deadLag", 32'(dead), 32'd0);
    stepTo(165); checkVal("deadE165", 32'(dead), 32'd1);
    checkVal("sickDead", 32'(sick), 32'd0);

    tc = 0;
    for (int k = 0; k < 20; k++) begin
      stepTo(ecnt + 1);
      if (tick) tc++;
    end
    checkVal("deadNoTick", 32'(tc), 32'd0);
    care = 4'b1111; stepTo(ecnt + 1); care = '0;
    checkVal("deadCareLvl", 32'(level), pk(0, 7, 7, 6));
    checkVal("deadHealth", 32'(health), 32'd0);

    // One-edge reset out of DEAD
    decayPeriod = c_PERIODS;
    rst = 1'b0; stepTo(ecnt + 1); rst = 1'b1; ecnt = 0;
    checkVal("reLevel", 32'(level), pk(7, 7, 7, 7));
    checkVal("reHealth", 32'(health), 32'd7);
    checkVal("reDead", 32'(dead), 32'd0);

    // Pause at the tick count: prescaler held, tick gated
    stepTo(3); checkVal("preTick", 32'(tick), 32'd1);
    pause = 1'b1; #1;
    checkVal("pauseGate", 32'(tick), 32'd0);
    tc = 0;
    for (int k = 0; k < 20; k++) begin
      stepTo(ecnt + 1);
      if (tick) tc++;
    end
    checkVal("pauseNoTick", 32'(tc), 32'd0);
    checkVal("pauseLvl", 32'(level), pk(7, 7, 7, 7));
    pause = 1'b0; #1;
    checkVal("resumeTick", 32'(tick), 32'd1);
    stepTo(ecnt + 1);
    checkVal("resumeLvl", 32'(level), pk(6, 7, 7, 7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pet_need_engine
`default_nettype wire

// File: doc/pet_need_engine.md
Name: pet_need_engine

Overview:
- Parametrised successor to the pet's fixed five-register need logic.
- Holds N_NEEDS independent need levels, each decaying by one step per run-time programmable number of ticks, and accepts per-channel care pulses that replenish a level.
- Derives a health level and a life-state FSM (ALIVE/SICK/DEAD) from the need levels.
- Sits between the button/command decoder (care pulses) and the display/sprite logic (levels, flags).

Parameters:
- N_NEEDS, 4: number of need channels.
- LVL_W, 3: level width; LVL_MAX = 2^LVL_W-1.
- TICK_DIV, 50000000: clk cycles per tick (1 s at 50 MHz); minimum 2.
- PERIOD_W, 8: width of each channel's decay period field.
- CARE_STEP, 3: level increment per care pulse.
- HIGH_THRESH, 5: all levels >= this enables health recovery.
- HEALTH_PERIOD, 10: ticks per health step, decay or recovery.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-low reset.
- pause, input, 1: high freezes the prescaler; no ticks are generated.
- decay_period, input, N_NEEDS*PERIOD_W: channel i period in ticks at bits [i*PERIOD_W +: PERIOD_W]; 0 disables decay for that channel.
- care, input, N_NEEDS: one-cycle care pulse per channel.
- level, output, N_NEEDS*LVL_W: registered need levels, channel i at [i*LVL_W +: LVL_W].
- low_flag, output, N_NEEDS: level_i < HIGH_THRESH, combinational from registered levels.
- health, output, LVL_W: registered health level.
- sick, output, 1: FSM in SICK.
- dead, output, 1: FSM in DEAD.
- tick, output, 1: internal tick strobe, one clk wide.

Behaviour:
- Reset (rst=0 at a clk edge):
  - all levels = LVL_MAX, health = LVL_MAX;
  - prescaler, decay counters and health timer = 0;
  - FSM = ALIVE, so sick=0, dead=0, tick=0.
  - Reset mid-operation overrides everything in the same edge, including DEAD.
- Prescaler:
  - pre counts 0..TICK_DIV-1 and wraps.
  - tick = (pre==TICK_DIV-1) && !pause && !dead.
  - pause or dead holds pre at its current value.
  - The first tick occurs on the TICK_DIV-th cycle after reset release.
- Per-channel decay, on each clk edge, in priority order:
  1. dead: no change.
  2. care_i: level_i <= min(level_i+CARE_STEP, LVL_MAX) with no overflow wrap (compute in LVL_W+1 bits); dcnt_i <= 0. Care wins over a simultaneous decay tick, so that decay is skipped.
  3. tick and period_i != 0 and dcnt_i >= period_i-1: level_i <= level_i-1, saturating at 0; dcnt_i <= 0. The >= compare makes a period reduced mid-count fire on the next tick.
  4. tick and period_i != 0: dcnt_i <= dcnt_i+1.
  5. period_i == 0: dcnt_i holds at 0.
  - Channels are fully independent; simultaneous care on several channels is all honoured.
- Life FSM (evaluated from registered values, so transitions lag the causing level change by 1 cycle):
  - ALIVE -> SICK when any level == 0.
  - SICK -> ALIVE when no level == 0.
  - ALIVE/SICK -> DEAD when health == 0; this has priority over all other transitions.
  - DEAD is terminal until reset.
- Health timer htmr:
  - Counts ticks while in SICK, or in ALIVE with all levels >= HIGH_THRESH; otherwise htmr <= 0.
  - htmr is cleared on every FSM state change.
  - On tick with htmr == HEALTH_PERIOD-1: htmr <= 0, and
    - SICK: health -1, saturating at 0;
    - ALIVE: health +1, saturating at LVL_MAX.
- DEAD:
  - levels and health frozen, care ignored, tick=0.
  - dead=1, sick=0.

Test Plan (TICK_DIV=4, N_NEEDS=4, LVL_W=3, CARE_STEP=3, HIGH_THRESH=5, HEALTH_PERIOD=2, periods {2,3,0,1}):
1. Release reset, no care -> tick at cycles 4, 8, 12...; ch0 7->6 at cycle 8; ch1 7->6 at cycle 12; ch3 drops 1 per tick; ch2 stays 7 throughout.
2. care[1] with ch1=7 -> stays 7. care[1] with ch1=2 -> 5 and dcnt1 restarts. care[0] on the same edge as ch0's decay tick -> level +3 and no decrement.
3. ch3 reaches 0 at tick 7 -> sick=1 one cycle later; health 7->6 after 2 further ticks, then -1 every 2 ticks; care[3] -> sick=0 next cycle and htmr cleared.
4. All levels >= 5 with health=4, ALIVE -> health +1 every 2 ticks, saturating at 7.
5. Health reaches 0 -> dead=1 next cycle; tick stays 0; care pulses leave levels unchanged; rst=0 for one edge -> levels=7, health=7, dead=0.
6. pause=1 for 20 cycles -> no tick, pre held; release -> tick resumes, remaining prescaler count preserved.
